cdb_arbiter: RTL

Common Data Bus arbiter for the Tomasulo core. It collects completed results (reservation-station tag plus value) from the add/sub and mul/div functional units. It buffers one result per unit and broadcasts exactly one result per cycle on the CDB to the reservation stations and the register file. A rotating round-robin grant ensures no unit starves when several units finish in the same cycle.

---
 rtl/tomasulo_pkg.sv | 20 ++
 rtl/rr_picker.sv | 31 +++
 rtl/cdb_arbiter.sv | 80 ++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: widths, unit indices and the result
// bundle carried from functional units to the common data bus.
package tomasulo_pkg;

  localparam int N_REQ  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 8;
  localparam int SRC_W  = $clog2(N_REQ);

  localparam int UNIT_ADD0 = 0;
  localparam int UNIT_ADD1 = 1;
  localparam int UNIT_MUL0 = 2;
  localparam int UNIT_MUL1 = 3;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } result_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after
// start (wrapping). Ports: req, start -> grant (one-hot/zero), idx, found.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding slot per functional unit, one
// round-robin broadcast per cycle. Ports: clock, reset, flush,
// req_valid/tag/value/ready per unit, registered cdb_valid/tag/value/src.
module cdb_arbiter
  import tomasulo_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_value,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_value,
  output logic [SRC_W-1:0]        cdb_src
);

  result_t          slot_q [N_REQ];
  logic [N_REQ-1:0] full_q;
  logic [SRC_W-1:0] ptr_q;

  logic [N_REQ-1:0] grant;
  logic [SRC_W-1:0] win;
  logic             found;
  logic [N_REQ-1:0] accept;
  logic [SRC_W-1:0] ptr_nxt;

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .req   (full_q),
    .start (ptr_q),
    .grant (grant),
    .idx   (win),
    .found (found)
  );

  // A slot being broadcast this edge frees up, so it may refill at once.
  assign req_ready = flush ? '0 : (~full_q | grant);
  assign accept    = req_valid & req_ready;
  assign ptr_nxt   = (win == SRC_W'(N_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q    <= '0;
      ptr_q     <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_q[i] <= '0;
      end
    end else if (flush) begin
      full_q    <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          full_q[i]       <= 1'b1;
          slot_q[i].tag   <= req_tag[i*TAG_W +: TAG_W];
          slot_q[i].value <= req_value[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          full_q[i] <= 1'b0;
        end
      end
      cdb_valid <= found;
      if (found) begin
        cdb_tag   <= slot_q[win].tag;
        cdb_value <= slot_q[win].value;
        cdb_src   <= win;
        ptr_q     <= ptr_nxt;
      end
    end
  end

endmodule
